// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - pipeline hazard/control bundle between the CPU datapath and the scheduler
//
// Purpose: groups the ID/EX/MEM hazard information and the pipeline-register
// control signals into one bundle.
//   master : the pipeline datapath (drives hazard info, receives controls)
//   slave  : hazard_scheduler (receives hazard info, drives controls)
// Signals:
//   id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jump_reg   - ID stage info
//   ex_rd, ex_reg_write, ex_mem_read, ex_mul_valid,
//   ex_branch_taken                                            - EX stage info
//   mem_rd, mem_mem_read                                       - MEM stage info
//   pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
//   exmem_flush                                                - pipeline controls
//   mul_busy, mul_done                                         - multiplier status
//   stall_count, flush_count                                   - performance counters
interface hazard_scheduler_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic                 id_jump;
  logic                 id_jump_reg;
  logic [4:0]           ex_rd;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic                 ex_mul_valid;
  logic                 ex_branch_taken;
  logic [4:0]           mem_rd;
  logic                 mem_mem_read;
  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_write;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 mul_busy;
  logic                 mul_done;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jump_reg,
    output ex_rd, ex_reg_write, ex_mem_read, ex_mul_valid, ex_branch_taken,
    output mem_rd, mem_mem_read,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush,
    input  mul_busy, mul_done, stall_count, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jump_reg,
    input  ex_rd, ex_reg_write, ex_mem_read, ex_mul_valid, ex_branch_taken,
    input  mem_rd, mem_mem_read,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush,
    output mul_busy, mul_done, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - stall/flush scheduler for the 5-stage pipeline CPU
//
// Purpose: sequences the multi-cycle multiplier held in EX, detects load-use
// and JR/JALR register hazards in ID, squashes wrong-path instructions on taken
// branches and jumps, and keeps saturating stall/flush counters.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - hazard_scheduler_if.slave (hazard info in, pipeline controls,
//           multiplier status and counters out)
// The interface CNT_WIDTH must match this module's CNT_WIDTH.
module hazard_scheduler #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH   = 32
) (
  input logic              clk,
  input logic              reset,
  hazard_scheduler_if.slave bus
);

  localparam logic [7:0] CNT_LOAD = 8'(MUL_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  logic mul_stall;
  logic load_use;
  logic jr_hazard;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_flush;
  logic exmem_flush;

  // The IDLE term stalls the very first multiply cycle; together with the
  // BUSY cycles while cnt != 0 that is exactly MUL_LATENCY stalls.
  assign mul_stall = ((state == IDLE) && bus.ex_mul_valid) ||
                     ((state == BUSY) && (cnt != 8'd0));

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

  // JR/JALR reads rs in ID, so it must wait for an ALU result still in EX or
  // a load result still in MEM.
  assign jr_hazard = bus.id_jump_reg && (bus.id_rs != 5'd0) &&
                     ((bus.ex_reg_write && (bus.ex_rd == bus.id_rs)) ||
                      (bus.mem_mem_read && (bus.mem_rd == bus.id_rs)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (mul_stall) begin
      // Freeze IF/ID/EX while the multiply occupies EX; feed MEM bubbles.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // Whatever sits in IF and ID is wrong-path, hazards there are moot.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use || jr_hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (bus.id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_mul_valid) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      if ((ifid_flush || idex_flush) && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_write  = idex_write;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.mul_busy    = (state == BUSY);
  assign bus.mul_done    = (state == BUSY) && (cnt == 8'd0);
  assign bus.stall_count = stall_count;
  assign bus.flush_count = flush_count;

endmodule
